// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// ahb_bus_arbiter - round-robin AHB grant arbiter with burst/lock protection
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic [3:0]             HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE       = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE << DEFAULT_MASTER;

  logic [4:0] len_m1;
  logic [4:0] cnt;
  logic [4:0] cnt_load;
  logic [4:0] remaining;
  logic [3:0] gnt_idx;
  logic [3:0] next_idx;
  logic       gnt_lock;
  logic       cur_lock;
  logic       arb_ok;

  always_comb begin
    case (HBURST)
      3'd2, 3'd3: len_m1 = 5'd3;
      3'd4, 3'd5: len_m1 = 5'd7;
      3'd6, 3'd7: len_m1 = 5'd15;
      default:    len_m1 = 5'd0;
    endcase
  end

  // cnt counts the beats left after the one now in the address phase, so the
  // beat following an accepted NONSEQ already has L-2 beats behind it.
  assign cnt_load  = (len_m1 == 5'd0) ? 5'd0 : len_m1 - 5'd1;
  assign remaining = (HTRANS == TRANS_NONSEQ) ? len_m1 : cnt;

  always_comb begin
    gnt_idx  = DEF_IDX;
    gnt_lock = 1'b0;
    cur_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) begin
        gnt_idx  = 4'(i);
        gnt_lock = HLOCK[i];
      end
      if (HMASTER == 4'(i)) cur_lock = HLOCK[i];
    end
  end

  // Walk the offsets from farthest to nearest so the nearest requester after
  // the current owner is the one that sticks.
  always_comb begin
    next_idx = DEF_IDX;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (HBUSREQ[i] && ((int'(HMASTER) + k) % NUM_MASTERS) == i) next_idx = 4'(i);
      end
    end
  end

  assign arb_ok = ~(cur_lock | HMASTLOCK) & (remaining <= 5'd1);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HGRANT    <= DEF_GRANT;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      cnt       <= 5'd0;
    end else if (HREADY) begin
      if (arb_ok) HGRANT <= ONE << next_idx;
      HMASTER   <= gnt_idx;
      HMASTER_D <= HMASTER;
      HMASTLOCK <= gnt_lock;
      case (HTRANS)
        TRANS_NONSEQ: cnt <= cnt_load;
        TRANS_SEQ:    if (cnt != 5'd0) cnt <= cnt - 5'd1;
        TRANS_IDLE:   cnt <= 5'd0;
        default:      cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
